// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants and types for the 4-digit
// multiplexed 7-segment scanner.
package seven_seg_scanner_pkg;

   localparam int NUM_DIGITS = 4;

   typedef logic [1:0] digit_idx_t;

   // Active-high patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Display-path bundle: BCD word and masks in,
// segment/anode drive and frame pulse out.
interface seven_seg_scanner_if;
   import seven_seg_scanner_pkg::*;

   logic [4*NUM_DIGITS-1:0] bcd_in;
   logic [NUM_DIGITS-1:0]   blink_mask;
   logic [NUM_DIGITS-1:0]   dp_mask;
   logic                    blank_lz;
   logic [6:0]              seg;
   logic                    dp;
   logic [NUM_DIGITS-1:0]   an;
   logic                    frame_tick;

   modport master (
      output bcd_in, blink_mask, dp_mask, blank_lz,
      input  seg, dp, an, frame_tick
   );

   modport slave (
      input  bcd_in, blink_mask, dp_mask, blank_lz,
      output seg, dp, an, frame_tick
   );

endinterface

// File: rtl/seven_seg_scanner_bcd_to_seg7.sv
// Nibble to active-high 7-segment pattern;
// non-decimal nibbles render as a dash.
module seven_seg_scanner_bcd_to_seg7
   import seven_seg_scanner_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_DASH;
      case (nib_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit 7-segment driver with
// per-frame snapshot, blink, dp, LZ blanking, dead time.
module seven_seg_scanner
   import seven_seg_scanner_pkg::*;
#(
   parameter int REFRESH_DIV    = 100000,
   parameter int DEAD_CYCLES    = 16,
   parameter int BLINK_FRAMES   = 125,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input logic          clk,
   input logic          rst_n,
   seven_seg_scanner_if.slave bus
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam int BW =
      (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [6:0] SEG_INV = {7{SEG_ACTIVE_LOW}};
   localparam logic [3:0] AN_INV  = {4{AN_ACTIVE_LOW}};

   logic [PW-1:0]  presc_q, presc_d;
   digit_idx_t     sel_q, sel_d;
   logic           pend_q;
   logic [15:0]    bcd_q;
   logic [3:0]     bm_q, dm_q;
   logic           lz_q;
   logic [BW-1:0]  bcnt_q, bcnt_d;
   logic           phase_q, phase_d;
   logic [6:0]     seg_q, seg_d;
   logic [3:0]     an_q, an_d;
   logic           dp_q, dp_d;
   logic           tick_q;

   logic           wrap, snap, bwrap;
   logic           dead, sup;
   logic [3:0]     nib;
   logic [6:0]     seg_dec;

   seven_seg_scanner_bcd_to_seg7 u_dec (
      .nib_i (nib),
      .seg_o (seg_dec)
   );

   always_comb begin
      wrap  = (presc_q == PW'(REFRESH_DIV - 1));
      snap  = pend_q | (wrap & (sel_q == 2'd3));
      bwrap = (bcnt_q == BW'(BLINK_FRAMES - 1));

      // scanning holds until the first frame is latched
      presc_d = presc_q;
      sel_d   = sel_q;
      if (!pend_q) begin
         presc_d = wrap ? '0 : presc_q + PW'(1);
         if (wrap) sel_d = sel_q + 2'd1;
      end

      bcnt_d  = bcnt_q;
      phase_d = phase_q;
      if (snap) begin
         bcnt_d  = bwrap ? '0 : bcnt_q + BW'(1);
         phase_d = phase_q ^ bwrap;
      end
   end

   always_comb begin
      nib = bcd_q[3:0];
      unique case (sel_q)
         2'd0: nib = bcd_q[3:0];
         2'd1: nib = bcd_q[7:4];
         2'd2: nib = bcd_q[11:8];
         2'd3: nib = bcd_q[15:12];
      endcase

      dead = (presc_q < PW'(DEAD_CYCLES));
      sup  = (phase_q & bm_q[sel_q])
           | ((sel_q == 2'd3) & lz_q & (nib == 4'd0));

      seg_d = SEG_OFF;
      an_d  = 4'h0;
      dp_d  = 1'b0;
      if (!pend_q) begin
         seg_d = seg_dec;
         dp_d  = dm_q[sel_q] & ~sup;
         if (!dead && !sup) an_d = 4'b0001 << sel_q;
      end
      seg_d = seg_d ^ SEG_INV;
      an_d  = an_d ^ AN_INV;
      dp_d  = dp_d ^ SEG_ACTIVE_LOW;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
         sel_q   <= '0;
         pend_q  <= 1'b1;
         bcd_q   <= '0;
         bm_q    <= '0;
         dm_q    <= '0;
         lz_q    <= 1'b0;
         bcnt_q  <= '0;
         phase_q <= 1'b0;
         seg_q   <= SEG_OFF ^ SEG_INV;
         an_q    <= AN_INV;
         dp_q    <= SEG_ACTIVE_LOW;
         tick_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         sel_q   <= sel_d;
         pend_q  <= 1'b0;
         bcnt_q  <= bcnt_d;
         phase_q <= phase_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
         dp_q    <= dp_d;
         tick_q  <= snap;
         if (snap) begin
            bcd_q <= bus.bcd_in;
            bm_q  <= bus.blink_mask;
            dm_q  <= bus.dp_mask;
            lz_q  <= bus.blank_lz;
         end
      end
   end

   assign bus.seg        = seg_q;
   assign bus.an         = an_q;
   assign bus.dp         = dp_q;
   assign bus.frame_tick = tick_q;

endmodule
